// File: rtl/branch_predictor_if.sv
// Fetch-lookup / execute-update channel between the pipeline and the branch predictor.
// The pipeline drives the master modport; the predictor uses the slave modport.
interface branch_predictor_if #(
    parameter int PC_W   = 32,
    parameter int STAT_W = 32
);
    logic [PC_W-1:0]   if_pc;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;

    logic              upd_valid;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic [PC_W-1:0]   upd_target;
    logic              upd_pred_taken;
    logic [PC_W-1:0]   upd_pred_target;
    logic              mispredict;
    logic [PC_W-1:0]   correct_pc;

    logic              enable;
    logic              flush;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, enable, flush,
        input  pred_taken, pred_target, mispredict, correct_pc,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, enable, flush,
        output pred_taken, pred_target, mispredict, correct_pc,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency IF lookup, EX-stage training,
// plus saturating branch/mispredict statistics for the LED display.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 8,
    parameter int PC_W    = 32,
    parameter int STAT_W  = 32
) (
    input logic               clk,
    input logic               CPU_RESETN,
    branch_predictor_if.slave bp
);

    localparam int                TAG_LO   = IDX_W + 2;
    localparam int                TAG_HI   = IDX_W + TAG_W + 1;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;
    localparam logic [PC_W-1:0]   PC_STEP  = PC_W'(4);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];

    logic [STAT_W-1:0]  branches_q;
    logic [STAT_W-1:0]  mispredicts_q;

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;
    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;
    logic               up_fire;
    logic               wrong_dir;
    logic               wrong_tgt;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    assign lk_idx  = bp.if_pc[IDX_W+1:2];
    assign lk_tag  = bp.if_pc[TAG_HI:TAG_LO];
    assign up_idx  = bp.upd_pc[IDX_W+1:2];
    assign up_tag  = bp.upd_pc[TAG_HI:TAG_LO];
    assign up_fire = bp.upd_valid & bp.enable;

    // Lookup reads only the registered table, so a same-cycle update is never visible here.
    always_comb begin
        lk_hit         = valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
        bp.pred_taken  = 1'b0;
        bp.pred_target = bp.if_pc + PC_STEP;
        if (lk_hit && cnt_q[lk_idx][1]) begin
            bp.pred_taken  = 1'b1;
            bp.pred_target = target_q[lk_idx];
        end
    end

    always_comb begin
        up_hit        = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
        wrong_dir     = bp.upd_taken != bp.upd_pred_taken;
        wrong_tgt     = bp.upd_taken & (bp.upd_pred_target != bp.upd_target);
        bp.mispredict = up_fire & (wrong_dir | wrong_tgt);
        bp.correct_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + PC_STEP;
    end

    // Flush wins over a same-cycle update; it only clears valid bits, leaving the payload stale.
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
        end else if (bp.enable) begin
            if (bp.flush) begin
                valid_q <= '0;
            end else if (bp.upd_valid) begin
                if (up_hit) begin
                    if (bp.upd_taken) begin
                        cnt_q[up_idx]    <= sat_inc(cnt_q[up_idx]);
                        target_q[up_idx] <= bp.upd_target;
                    end else begin
                        cnt_q[up_idx]    <= sat_dec(cnt_q[up_idx]);
                    end
                end else if (bp.upd_taken) begin
                    valid_q[up_idx]  <= 1'b1;
                    tag_q[up_idx]    <= up_tag;
                    target_q[up_idx] <= bp.upd_target;
                    cnt_q[up_idx]    <= 2'b10;
                end
            end
        end
    end

    // Statistics still count updates that a flush discarded from the table.
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            if (up_fire && branches_q != STAT_MAX) begin
                branches_q <= branches_q + 1'b1;
            end
            if (bp.mispredict && mispredicts_q != STAT_MAX) begin
                mispredicts_q <= mispredicts_q + 1'b1;
            end
        end
    end

    assign bp.stat_branches    = branches_q;
    assign bp.stat_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor; a second narrow-stat, 2-entry copy
// follows the same traffic to exercise statistics saturation.
module tb_branch_predictor;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    branch_predictor_if #(.PC_W(32), .STAT_W(32)) bus ();
    branch_predictor_if #(.PC_W(32), .STAT_W(2))  bus2 ();

    branch_predictor #(.ENTRIES(16), .TAG_W(8), .PC_W(32), .STAT_W(32)) dut (
        .clk        (clk),
        .CPU_RESETN (rst_n),
        .bp         (bus)
    );

    branch_predictor #(.ENTRIES(2), .TAG_W(8), .PC_W(32), .STAT_W(2)) dut_small (
        .clk        (clk),
        .CPU_RESETN (rst_n),
        .bp         (bus2)
    );

    assign bus2.if_pc           = bus.if_pc;
    assign bus2.upd_valid       = bus.upd_valid;
    assign bus2.upd_pc          = bus.upd_pc;
    assign bus2.upd_taken       = bus.upd_taken;
    assign bus2.upd_target      = bus.upd_target;
    assign bus2.upd_pred_taken  = bus.upd_pred_taken;
    assign bus2.upd_pred_target = bus.upd_pred_target;
    assign bus2.enable          = bus.enable;
    assign bus2.flush           = bus.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic tk,
                                 input logic [31:0] tgt, input logic ptk,
                                 input logic [31:0] ptgt);
        bus.upd_valid       = v;
        bus.upd_pc          = pc;
        bus.upd_taken       = tk;
        bus.upd_target      = tgt;
        bus.upd_pred_taken  = ptk;
        bus.upd_pred_target = ptgt;
        #1;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bus.if_pc = pc;
        #1;
    endtask

    task automatic checkPred(input string tag, input logic tk, input logic [31:0] tgt);
        checkOutput({tag, "_taken"}, 32'(bus.pred_taken), 32'(tk));
        checkOutput({tag, "_target"}, bus.pred_target, tgt);
    endtask

    task automatic checkStats(input string tag, input int br, input int mp);
        checkOutput({tag, "_branches"}, bus.stat_branches, 32'(br));
        checkOutput({tag, "_mispredicts"}, bus.stat_mispredicts, 32'(mp));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.if_pc = 32'h40;
        bus.enable = 1'b1;
        bus.flush  = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        $display("[TB] reset state");
        checkPred("in_reset", 1'b0, 32'h44);
        checkStats("in_reset", 0, 0);
        rst_n = 1'b1;
        clockEdge();
        lookup(32'h40);
        checkPred("post_reset", 1'b0, 32'h44);
        checkStats("post_reset", 0, 0);

        $display("[TB] allocate 0x40 -> 0x100");
        applyStimulus(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        checkOutput("alloc_mispredict", 32'(bus.mispredict), 32'd1);
        checkOutput("alloc_correct_pc", bus.correct_pc, 32'h100);
        checkPred("alloc_same_cycle_old", 1'b0, 32'h44);
        clockEdge();
        lookup(32'h40);
        checkPred("alloc_lookup", 1'b1, 32'h100);
        checkStats("alloc", 1, 1);

        $display("[TB] counter saturation");
        applyStimulus(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        checkOutput("taken_ok_mispredict", 32'(bus.mispredict), 32'd0);
        clockEdge();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
            clockEdge();
        end
        checkStats("sat_up", 4, 1);
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        checkOutput("nt1_mispredict", 32'(bus.mispredict), 32'd1);
        checkOutput("nt1_correct_pc", bus.correct_pc, 32'h44);
        clockEdge();
        lookup(32'h40);
        checkPred("nt1_still_taken", 1'b1, 32'h100);
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        clockEdge();
        checkPred("nt2_not_taken", 1'b0, 32'h44);
        checkStats("nt2", 6, 3);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'h40, 1'b0, 32'h100, 1'b0, 32'h44);
            checkOutput("nt_floor_mispredict", 32'(bus.mispredict), 32'd0);
            clockEdge();
        end
        applyStimulus(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        clockEdge();
        checkPred("floor_held_at_00", 1'b0, 32'h44);
        checkStats("floor", 9, 4);

        $display("[TB] wrong-target mispredict retargets entry");
        applyStimulus(1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h100);
        checkOutput("tgt_mispredict", 32'(bus.mispredict), 32'd1);
        checkOutput("tgt_correct_pc", bus.correct_pc, 32'h200);
        clockEdge();
        checkPred("retarget", 1'b1, 32'h200);
        checkStats("retarget", 10, 5);

        $display("[TB] aliasing 0x440 onto 0x40");
        applyStimulus(1'b1, 32'h440, 1'b1, 32'h300, 1'b0, 32'h444);
        clockEdge();
        lookup(32'h40);
        checkPred("alias_old_miss", 1'b0, 32'h44);
        lookup(32'h440);
        checkPred("alias_new_hit", 1'b1, 32'h300);
        checkStats("alias", 11, 6);

        $display("[TB] second entry and miss not-taken");
        lookup(32'h48);
        applyStimulus(1'b1, 32'h48, 1'b1, 32'h500, 1'b0, 32'h4c);
        checkPred("alloc48_same_cycle_old", 1'b0, 32'h4c);
        clockEdge();
        lookup(32'h48);
        checkPred("alloc48", 1'b1, 32'h500);
        applyStimulus(1'b1, 32'h80, 1'b0, 32'h900, 1'b0, 32'h84);
        checkOutput("miss_nt_mispredict", 32'(bus.mispredict), 32'd0);
        checkOutput("miss_nt_correct_pc", bus.correct_pc, 32'h84);
        clockEdge();
        lookup(32'h80);
        checkPred("miss_nt_no_alloc", 1'b0, 32'h84);
        checkStats("miss_nt", 13, 7);

        $display("[TB] flush with simultaneous update");
        bus.flush = 1'b1;
        applyStimulus(1'b1, 32'h48, 1'b1, 32'h600, 1'b1, 32'h500);
        checkOutput("flush_mispredict", 32'(bus.mispredict), 32'd1);
        clockEdge();
        bus.flush = 1'b0;
        lookup(32'h440);
        checkPred("flush_miss_440", 1'b0, 32'h444);
        lookup(32'h48);
        checkPred("flush_miss_48", 1'b0, 32'h4c);
        checkStats("flush", 14, 8);

        $display("[TB] enable low freezes state");
        applyStimulus(1'b1, 32'h40, 1'b1, 32'h700, 1'b0, 32'h44);
        clockEdge();
        lookup(32'h40);
        checkPred("realloc", 1'b1, 32'h700);
        checkStats("realloc", 15, 9);
        bus.enable = 1'b0;
        bus.flush  = 1'b1;
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h700, 1'b1, 32'h700);
        checkOutput("disabled_mispredict", 32'(bus.mispredict), 32'd0);
        checkOutput("disabled_correct_pc", bus.correct_pc, 32'h44);
        clockEdge();
        bus.flush = 1'b0;
        checkPred("disabled_frozen", 1'b1, 32'h700);
        checkStats("disabled", 15, 9);
        lookup(32'h100);
        checkPred("disabled_tracks_pc", 1'b0, 32'h104);
        checkOutput("small_branches_sat", 32'(bus2.stat_branches), 32'd3);
        checkOutput("small_mispredicts_sat", 32'(bus2.stat_mispredicts), 32'd3);

        $display("[TB] asynchronous reset mid-update");
        bus.enable = 1'b1;
        lookup(32'h40);
        applyStimulus(1'b1, 32'h40, 1'b1, 32'h800, 1'b0, 32'h44);
        rst_n = 1'b0;
        #1;
        checkStats("async_reset", 0, 0);
        checkPred("async_reset", 1'b0, 32'h44);
        checkOutput("small_async_reset", 32'(bus2.stat_branches), 32'd0);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        rst_n = 1'b1;
        clockEdge();
        lookup(32'h40);
        checkPred("after_reset_update_dropped", 1'b0, 32'h44);
        checkStats("after_reset", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage pipeline. It replaces static "predict not-taken, flush on EX resolve".
- IF stage: combinational lookup of a direct-mapped BTB with 2-bit saturating counters gives a predicted next PC.
- EX stage: resolved branch/jump outcomes train the table.
- Keeps saturating statistics counters (resolved branches, mispredicts) for the LED display path.

Parameters:
- ENTRIES, 16, number of BTB entries; power of 2, minimum 2.
- IDX_W, $clog2(ENTRIES), index width (derived; do not override).
- TAG_W, 8, tag bits stored per entry.
- PC_W, 32, PC and target width.
- STAT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  pipeline clock.
- CPU_RESETN  in  1  asynchronous active-low reset.
- if_pc  in  PC_W  PC of the instruction being fetched.
- pred_taken  out  1  predicted taken for if_pc.
- pred_target  out  PC_W  predicted next PC: entry target if pred_taken, else if_pc+4.
- upd_valid  in  1  EX-stage resolved branch/jump present; qualified by enable.
- upd_pc  in  PC_W  PC of the resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_W  actual taken target.
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction.
- upd_pred_target  in  PC_W  predicted next PC carried down the pipe.
- mispredict  out  1  combinational: upd_valid & enable & prediction wrong.
- correct_pc  out  PC_W  redirect PC: upd_target if upd_taken, else upd_pc+4.
- enable  in  1  pipeline enable (pcEnable); when 0 no state changes.
- flush  in  1  synchronous invalidate of all entries.
- stat_branches  out  STAT_W  count of resolved upd_valid events.
- stat_mispredicts  out  STAT_W  count of mispredicts.

Behaviour:
- Address slicing:
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag[TAG_W], target[PC_W], cnt[2].
- Lookup is purely combinational, zero latency:
  - hit = valid[idx] & (tag[idx] == if_tag).
  - pred_taken = hit & cnt[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc + 4 (modulo 2^PC_W).
- Mispredict:
  - mispredict = upd_valid & enable & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_target != upd_target)).
  - correct_pc is valid whenever upd_valid.
- Update occurs at the rising clk edge when upd_valid & enable:
  - Hit, taken: cnt saturating increment (max 2'b11); target <= upd_target.
  - Hit, not taken: cnt saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate by overwriting the entry. valid=1, tag=upd tag, target=upd_target, cnt=2'b10 (weakly taken).
  - Miss, not taken: no change.
- Lookup and update in the same cycle return the old entry contents. Write-first bypass is not allowed.
- flush & enable: all valid bits cleared at the edge. Targets, tags and counters are not cleared.
- flush has priority over an update in the same cycle; the update is dropped, but stats still count it.
- Stats, each saturating at all-ones (no wrap):
  - stat_branches += 1 on upd_valid & enable.
  - stat_mispredicts += 1 on mispredict.
- Reset (asynchronous, CPU_RESETN low): all valid=0, cnt=2'b01, tags/targets=0, both stats=0.
  - During reset, pred_taken=0 and pred_target=if_pc+4.
  - Release is synchronous to the next clk edge. Reset mid-update discards the update.
- enable=0: table and stats frozen; outputs keep tracking the inputs combinationally.

Test Plan:
1. After reset, if_pc=0x0040 -> pred_taken=0, pred_target=0x0044, both stats=0.
2. Allocate: upd_valid, upd_pc=0x0040, taken, target=0x0100, upd_pred_taken=0.
   - Response: mispredict=1, correct_pc=0x0100.
   - Next cycle, lookup 0x0040 -> pred_taken=1, pred_target=0x0100; stats 1/1.
3. Counter saturation on the same entry: 3 taken updates then 1 not-taken.
   - Response: still predicts taken (cnt 11->10).
   - A second not-taken -> pred_taken=0 (cnt 01).
   - Further not-taken updates hold cnt at 00.
4. Aliasing, ENTRIES=16: allocate 0x0040, then taken update at 0x0440 (same idx, different tag).
   - Response: lookup 0x0040 misses (pred_target=0x0044); lookup 0x0440 hits.
5. Simultaneous flush and upd_valid with enable=1 -> all lookups miss next cycle; stat_branches incremented.
6. enable=0 with upd_valid=1 and flush=1 -> mispredict=0, no table or stat change.
   - Then assert CPU_RESETN=0 asynchronously mid-cycle -> stats read 0 immediately.
